// File: rtl/lsu_ctl.sv
// Load/store unit controller: one outstanding access, aligns store data/mask into a RAM word,
// extracts and extends load data, and flags misalignment or a RAM timeout.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 3
`define RAM_BYT_1_S 3'd0
`define RAM_BYT_1_U 3'd1
`define RAM_BYT_2_S 3'd2
`define RAM_BYT_2_U 3'd3
`define RAM_BYT_4_S 3'd4
`define RAM_BYT_4_U 3'd5
`define RAM_BYT_8_U 3'd6
`endif

module lsu_ctl #(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
    parameter int unsigned MAX_WAIT   = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_wr,
    input  logic [`ARGS_WIDTH-1:0]  i_req_byt,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic                    o_ram_rd_en,
    output logic [ADDR_WIDTH-1:0]   o_ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]   i_ram_rd_data,
    input  logic                    i_ram_rd_vld,
    output logic                    o_ram_wr_en,
    output logic [ADDR_WIDTH-1:0]   o_ram_wr_addr,
    output logic [DATA_WIDTH-1:0]   o_ram_wr_data,
    output logic [DATA_WIDTH/8-1:0] o_ram_wr_mask,
    input  logic                    i_ram_wr_ack
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    typedef enum logic [1:0] {StIdle, StLoad, StStore, StResp} state_e;

    state_e                 state_q;
    logic [7:0]             cnt_q;
    logic [`ARGS_WIDTH-1:0] byt_q;
    logic [OFF_W-1:0]       off_q;

    // Size in bytes for a code; 0 marks an unknown code.
    function automatic logic [3:0] byt_size(input logic [`ARGS_WIDTH-1:0] b);
        case (b)
            `RAM_BYT_1_S, `RAM_BYT_1_U: byt_size = 4'd1;
            `RAM_BYT_2_S, `RAM_BYT_2_U: byt_size = 4'd2;
            `RAM_BYT_4_S, `RAM_BYT_4_U: byt_size = 4'd4;
            `RAM_BYT_8_U:               byt_size = 4'd8;
            default:                    byt_size = 4'd0;
        endcase
    endfunction

    logic [OFF_W-1:0]      req_off;
    logic [3:0]            req_size;
    logic [OFF_W-1:0]      req_size_m1;
    logic                  req_bad;
    logic [ADDR_WIDTH-1:0] req_waddr;
    logic [DATA_WIDTH-1:0] req_wdata_sh;
    logic [NB-1:0]         req_mask;

    always_comb begin
        req_off      = i_req_addr[OFF_W-1:0];
        req_size     = byt_size(i_req_byt);
        req_size_m1  = OFF_W'(req_size - 4'd1);
        req_bad      = (req_size == 4'd0) || (int'(req_size) > NB) ||
                       ((req_off & req_size_m1) != '0);
        req_waddr    = {i_req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        req_wdata_sh = i_req_wdata << {req_off, 3'b000};
        req_mask     = '0;
        for (int i = 0; i < int'(NB); i++) begin
            req_mask[i] = (i >= int'(req_off)) && (i < int'(req_off) + int'(req_size));
        end
    end

    logic [3:0]            ld_size;
    logic                  ld_signed;
    logic                  ld_sign;
    logic [DATA_WIDTH-1:0] ld_sh;
    logic [DATA_WIDTH-1:0] ld_keep;
    logic [DATA_WIDTH-1:0] ld_ext;

    always_comb begin
        ld_size   = byt_size(byt_q);
        ld_signed = (byt_q == `RAM_BYT_1_S) || (byt_q == `RAM_BYT_2_S) ||
                    (byt_q == `RAM_BYT_4_S);
        ld_sh     = i_ram_rd_data >> {off_q, 3'b000};
        ld_sign   = 1'b0;
        ld_keep   = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            ld_keep[i] = (i < 8 * int'(ld_size));
            if (i == 8 * int'(ld_size) - 1) ld_sign = ld_sh[i];
        end
        ld_ext = (ld_sh & ld_keep) | ((ld_signed && ld_sign) ? ~ld_keep : '0);
    end

    assign o_req_ready = (state_q == StIdle);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            byt_q         <= '0;
            off_q         <= '0;
            o_rsp_valid   <= 1'b0;
            o_rsp_rdata   <= '0;
            o_rsp_err     <= 1'b0;
            o_ram_rd_en   <= 1'b0;
            o_ram_rd_addr <= '0;
            o_ram_wr_en   <= 1'b0;
            o_ram_wr_addr <= '0;
            o_ram_wr_data <= '0;
            o_ram_wr_mask <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_req_valid) begin
                        byt_q <= i_req_byt;
                        off_q <= req_off;
                        cnt_q <= '0;
                        if (req_bad) begin
                            state_q     <= StResp;
                            o_rsp_valid <= 1'b1;
                            o_rsp_err   <= 1'b1;
                            o_rsp_rdata <= '0;
                        end else if (i_req_wr) begin
                            state_q       <= StStore;
                            o_ram_wr_en   <= 1'b1;
                            o_ram_wr_addr <= req_waddr;
                            o_ram_wr_data <= req_wdata_sh;
                            o_ram_wr_mask <= req_mask;
                        end else begin
                            state_q       <= StLoad;
                            o_ram_rd_en   <= 1'b1;
                            o_ram_rd_addr <= req_waddr;
                        end
                    end
                end
                StLoad: begin
                    if (i_ram_rd_vld || cnt_q == 8'(MAX_WAIT - 1)) begin
                        // Data arriving on the final allowed cycle still completes normally.
                        state_q       <= StResp;
                        o_ram_rd_en   <= 1'b0;
                        o_ram_rd_addr <= '0;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_err     <= !i_ram_rd_vld;
                        o_rsp_rdata   <= i_ram_rd_vld ? ld_ext : '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StStore: begin
                    if (i_ram_wr_ack || cnt_q == 8'(MAX_WAIT - 1)) begin
                        state_q       <= StResp;
                        o_ram_wr_en   <= 1'b0;
                        o_ram_wr_addr <= '0;
                        o_ram_wr_data <= '0;
                        o_ram_wr_mask <= '0;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_err     <= !i_ram_wr_ack;
                        o_rsp_rdata   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        state_q     <= StIdle;
                        o_rsp_valid <= 1'b0;
                        o_rsp_err   <= 1'b0;
                        o_rsp_rdata <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctl.sv
// Self-checking bench for lsu_ctl (64-bit data): scoreboard of expected responses plus
// cycle-accurate checks of the RAM-side strobes.
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 3
`define RAM_BYT_1_S 3'd0
`define RAM_BYT_1_U 3'd1
`define RAM_BYT_2_S 3'd2
`define RAM_BYT_2_U 3'd3
`define RAM_BYT_4_S 3'd4
`define RAM_BYT_4_U 3'd5
`define RAM_BYT_8_U 3'd6
`endif

module tb_lsu_ctl;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wr = 1'b0;
    logic [2:0]    req_byt = '0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data = '0;
    logic          ram_rd_vld = 1'b0;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [7:0]    ram_wr_mask;
    logic          ram_wr_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;
    rsp_t sb_q[$];

    lsu_ctl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_wr      (req_wr),
        .i_req_byt     (req_byt),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_err     (rsp_err),
        .o_ram_rd_en   (ram_rd_en),
        .o_ram_rd_addr (ram_rd_addr),
        .i_ram_rd_data (ram_rd_data),
        .i_ram_rd_vld  (ram_rd_vld),
        .o_ram_wr_en   (ram_wr_en),
        .o_ram_wr_addr (ram_wr_addr),
        .o_ram_wr_data (ram_wr_data),
        .o_ram_wr_mask (ram_wr_mask),
        .i_ram_wr_ack  (ram_wr_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there or at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pops the scoreboard on every accepted response.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                check_eq("rsp_rdata", rsp_rdata, e.rdata);
                check_eq("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
            end
        end
    end

    // lat = cycle (1-based) on which vld/ack arrives; 0 means never (timeout).
    task automatic run_txn(input string name, input logic wr, input logic [2:0] byt,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int lat, input logic [DW-1:0] rd_in, input bit bad,
                           input logic [AW-1:0] exp_waddr, input logic [DW-1:0] exp_wdata,
                           input logic [7:0] exp_mask, input logic [DW-1:0] exp_rdata,
                           input logic exp_err, input int stall);
        int n;
        rsp_t e;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        if (stall > 0) rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_byt   = byt;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        req_wr    = ~wr;
        req_byt   = byt ^ 3'd1;
        req_addr  = ~addr;
        req_wdata = ~wdata;
        if (bad) begin
            check_eq({name, "_bad_rd_en"}, {63'd0, ram_rd_en}, 64'd0);
            check_eq({name, "_bad_wr_en"}, {63'd0, ram_wr_en}, 64'd0);
            check_eq({name, "_bad_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
        end else begin
            n = (lat == 0) ? MW : lat;
            for (int k = 1; k <= n; k++) begin
                if (wr) begin
                    check_eq({name, "_wr_en"}, {63'd0, ram_wr_en}, 64'd1);
                    check_eq({name, "_rd_en_off"}, {63'd0, ram_rd_en}, 64'd0);
                    check_eq({name, "_wr_addr"}, {32'd0, ram_wr_addr}, {32'd0, exp_waddr});
                    check_eq({name, "_wr_data"}, ram_wr_data, exp_wdata);
                    check_eq({name, "_wr_mask"}, {56'd0, ram_wr_mask}, {56'd0, exp_mask});
                    if (k == lat) ram_wr_ack = 1'b1;
                    else ram_rd_vld = 1'b1;
                end else begin
                    check_eq({name, "_rd_en"}, {63'd0, ram_rd_en}, 64'd1);
                    check_eq({name, "_wr_en_off"}, {63'd0, ram_wr_en}, 64'd0);
                    check_eq({name, "_rd_addr"}, {32'd0, ram_rd_addr}, {32'd0, exp_waddr});
                    if (k == lat) begin
                        ram_rd_vld  = 1'b1;
                        ram_rd_data = rd_in;
                    end else begin
                        ram_wr_ack = 1'b1;
                    end
                end
                tick();
                ram_rd_vld  = 1'b0;
                ram_wr_ack  = 1'b0;
                ram_rd_data = 64'h5A5A_5A5A_5A5A_5A5A;
            end
            check_eq({name, "_rd_en_done"}, {63'd0, ram_rd_en}, 64'd0);
            check_eq({name, "_wr_en_done"}, {63'd0, ram_wr_en}, 64'd0);
            check_eq({name, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
        end
        for (int s = 0; s < stall; s++) begin
            check_eq({name, "_stall_valid"}, {63'd0, rsp_valid}, 64'd1);
            check_eq({name, "_stall_rdata"}, rsp_rdata, exp_rdata);
            check_eq({name, "_stall_ready"}, {63'd0, req_ready}, 64'd0);
            req_valid = 1'b1;
            req_wr    = 1'b0;
            req_byt   = `RAM_BYT_8_U;
            req_addr  = 32'h0000_0100;
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        while (rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq({name, "_drained"}, {63'd0, rsp_valid}, 64'd0);
        check_eq({name, "_idle_rd_en"}, {63'd0, ram_rd_en}, 64'd0);
        check_eq({name, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        #1;
        check_eq("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("rst_rd_en", {63'd0, ram_rd_en}, 64'd0);
        check_eq("rst_wr_en", {63'd0, ram_wr_en}, 64'd0);
        check_eq("rst_wr_mask", {56'd0, ram_wr_mask}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_txn("ld_h_s", 1'b0, `RAM_BYT_2_S, 32'h8000_0006, '0, 1, 64'h8765_0000_0000_0000,
                1'b0, 32'h8000_0000, '0, '0, 64'hFFFF_FFFF_FFFF_8765, 1'b0, 0);
        run_txn("st_b", 1'b1, `RAM_BYT_1_U, 32'h8000_0003, 64'hAB, 3, '0,
                1'b0, 32'h8000_0000, 64'h0000_0000_AB00_0000, 8'h08, '0, 1'b0, 0);
        run_txn("st_w_mis", 1'b1, `RAM_BYT_4_U, 32'h8000_0002, 64'h1234, 0, '0,
                1'b1, '0, '0, '0, '0, 1'b1, 0);
        run_txn("ld_tmo", 1'b0, `RAM_BYT_4_U, 32'h8000_0004, '0, 0, '0,
                1'b0, 32'h8000_0000, '0, '0, '0, 1'b1, 0);
        run_txn("ld_last", 1'b0, `RAM_BYT_4_U, 32'h8000_0004, '0, 15, 64'h1234_5678_9ABC_DEF0,
                1'b0, 32'h8000_0000, '0, '0, 64'h0000_0000_1234_5678, 1'b0, 0);
        run_txn("ld_w_s", 1'b0, `RAM_BYT_4_S, 32'h0000_0010, '0, 2, 64'h0000_0000_8000_0001,
                1'b0, 32'h0000_0010, '0, '0, 64'hFFFF_FFFF_8000_0001, 1'b0, 0);
        run_txn("ld_d", 1'b0, `RAM_BYT_8_U, 32'h0000_0018, '0, 1, 64'hDEAD_BEEF_CAFE_F00D,
                1'b0, 32'h0000_0018, '0, '0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 0);
        run_txn("ld_b_s", 1'b0, `RAM_BYT_1_S, 32'h0000_0021, '0, 1, 64'h0000_0000_0000_7F00,
                1'b0, 32'h0000_0020, '0, '0, 64'h0000_0000_0000_007F, 1'b0, 0);
        run_txn("st_h", 1'b1, `RAM_BYT_2_U, 32'h0000_0046, 64'hFFFF_FFFF_FFFF_1234, 2, '0,
                1'b0, 32'h0000_0040, 64'h1234_0000_0000_0000, 8'hC0, '0, 1'b0, 0);
        run_txn("st_d", 1'b1, `RAM_BYT_8_U, 32'h0000_0050, 64'h0123_4567_89AB_CDEF, 1, '0,
                1'b0, 32'h0000_0050, 64'h0123_4567_89AB_CDEF, 8'hFF, '0, 1'b0, 0);
        run_txn("ld_badcode", 1'b0, 3'd7, 32'h0000_0060, '0, 0, '0,
                1'b1, '0, '0, '0, '0, 1'b1, 0);
        run_txn("ld_h_mis", 1'b0, `RAM_BYT_2_U, 32'h0000_0061, '0, 0, '0,
                1'b1, '0, '0, '0, '0, 1'b1, 0);
        run_txn("ld_stall", 1'b0, `RAM_BYT_2_U, 32'h0000_0072, '0, 1, 64'h0000_0000_BEEF_0000,
                1'b0, 32'h0000_0070, '0, '0, 64'h0000_0000_0000_BEEF, 1'b0, 5);

        // Reset two cycles into a load: nothing may come back for it.
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_byt   = `RAM_BYT_4_U;
        req_addr  = 32'h0000_0080;
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("mid_rd_en", {63'd0, ram_rd_en}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rd_en", {63'd0, ram_rd_en}, 64'd0);
        check_eq("mid_rst_rd_addr", {32'd0, ram_rd_addr}, 64'd0);
        check_eq("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        ram_rd_vld  = 1'b1;
        ram_rd_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        ram_rd_vld = 1'b0;
        tick();
        check_eq("post_rst_ready", {63'd0, req_ready}, 64'd1);
        check_eq("post_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("post_rst_rd_en", {63'd0, ram_rd_en}, 64'd0);

        run_txn("ld_after_rst", 1'b0, `RAM_BYT_1_U, 32'h0000_0087, '0, 1,
                64'hA500_0000_0000_0000, 1'b0, 32'h0000_0080, '0, '0,
                64'h0000_0000_0000_00A5, 1'b0, 0);

        tick();
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_ctl.md
LSU_CTL -- requirements
Module: lsu_ctl

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default `DATA_WIDTH, memory/GPR data width (32 or 64 only).
REQ-002 SHALL provide parameter ADDR_WIDTH, default `ADDR_WIDTH, memory address width.
REQ-003 SHALL provide parameter MAX_WAIT, default 15, memory cycles allowed before timeout (1..255).
REQ-004 SHALL have ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request ready.
- i_req_wr  in  1  1 = store, 0 = load.
- i_req_byt  in  `ARGS_WIDTH  access size/sign code, `RAM_BYT_1_S/_U, `RAM_BYT_2_S/_U, `RAM_BYT_4_S/_U, `RAM_BYT_8_U.
- i_req_addr  in  ADDR_WIDTH  byte address.
- i_req_wdata  in  DATA_WIDTH  store data, right-aligned.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response ready.
- o_rsp_rdata  out  DATA_WIDTH  extended load data, 0 for stores/errors.
- o_rsp_err  out  1  misaligned or timeout.
- o_ram_rd_en, o_ram_rd_addr  out  1, ADDR_WIDTH  read request, word-aligned address.
- i_ram_rd_data, i_ram_rd_vld  in  DATA_WIDTH, 1  read data, valid.
- o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, o_ram_wr_mask  out  1, ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH/8  write request.
- i_ram_wr_ack  in  1  write accepted.

Function
REQ-005 SHALL implement FSM IDLE, LOAD, STORE, RESP; request accepted only when i_req_valid and o_req_ready in IDLE; o_req_ready = (state == IDLE).
REQ-006 SHALL latch addr, byt, wr, wdata on acceptance; later input changes ignored.
REQ-007 SHALL compute offset = addr[log2(DATA_WIDTH/8)-1:0]; size = 1/2/4/8 bytes from byt, S and U equal for size.
REQ-008 SHALL flag misaligned when offset mod size != 0, or size 8 with DATA_WIDTH 32 or unknown byt code; misaligned goes IDLE -> RESP directly, no RAM strobe, err=1, rdata=0.
REQ-009 SHALL drive o_ram_rd_addr/o_ram_wr_addr = addr with low offset bits cleared.
REQ-010 SHALL, in LOAD, hold o_ram_rd_en=1 until i_ram_rd_vld; on vld capture (i_ram_rd_data >> 8*offset), zero/sign-extend low size bytes per byt, go RESP.
REQ-011 SHALL, in STORE, hold o_ram_wr_en=1, wr_data = wdata << 8*offset, wr_mask = ((1<<size)-1) << offset, until i_ram_wr_ack, then go RESP with rdata=0, err=0.
REQ-012 SHALL count cycles spent in LOAD/STORE; count reaching MAX_WAIT without vld/ack aborts to RESP, err=1, rdata=0; vld/ack on that same cycle wins (normal completion).
REQ-013 SHALL keep rd/wr strobes 0 outside LOAD/STORE, and never both 1.
REQ-014 SHALL assert o_rsp_valid in RESP only, holding rdata/err stable until i_rsp_ready; RESP -> IDLE on i_rsp_ready.
REQ-015 SHALL give minimum latency: accept cycle 0, RAM strobe cycle 1, vld/ack cycle 1 -> o_rsp_valid cycle 2; misaligned -> o_rsp_valid cycle 1.
REQ-016 SHALL ignore i_ram_rd_vld / i_ram_wr_ack outside LOAD / STORE respectively.

Reset
REQ-017 SHALL, on i_rst_n low (any state, mid-transaction included), immediately enter IDLE, counter 0, o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0, all RAM strobes/addr/data/mask=0, o_req_ready=1 after release; aborted transaction produces no response.

Verification (DATA_WIDTH=64)
REQ-018 Load `RAM_BYT_2_S addr 0x8000_0006, rd_data 0x8765_0000_0000_0000 vld cycle 1 -> rd_addr 0x8000_0000, rdata 0xFFFF_FFFF_FFFF_8765, err 0, rsp_valid cycle 2.
REQ-019 Store `RAM_BYT_1_U addr 0x8000_0003 wdata 0xAB, ack after 3 cycles -> wr_addr 0x8000_0000, wr_data 0x0000_0000_AB00_0000, mask 0x08 held 3 cycles, rsp err 0.
REQ-020 Store `RAM_BYT_4_U addr 0x8000_0002 -> no wr_en pulse, rsp_valid cycle 1, err 1.
REQ-021 Load, no vld for MAX_WAIT=15 cycles -> rd_en drops, err 1, rdata 0; repeat with vld on 15th cycle -> err 0.
REQ-022 i_rsp_ready held 0 for 5 cycles -> rsp stable, o_req_ready 0, new i_req_valid not accepted.
REQ-023 Reset asserted 2 cycles into LOAD -> outputs zero immediately, no response after release, next request served normally.
